des_seq_ctrl: RTL and testbench

//  Scheduler that shares one 3-flop serial detector core (des_core) between
//  N_REQ requesters. Round-robin grants one requester, shifts its W-bit word
//  LSB-first into the core's x input, and collects z after every bit into a
//  W-bit result. Returns the result with the requester id over valid/ready.

---
 rtl/des_seq_ctrl_pkg.sv | 15 +
 rtl/des_seq_ctrl_core.sv | 32 +++
 rtl/des_seq_ctrl.sv | 118 +++++++++++
 tb/tb_des_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/des_seq_ctrl_pkg.sv
// Shared definitions for the serial-detector scheduler: FSM encoding and
// default sizing.
package des_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/des_seq_ctrl_core.sv
// Three-flop serial detector shared by all requesters; z is a pure decode
// of the flops, so it reflects the bit shifted in on the previous enabled edge.
module des_core (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic z
);

  logic w7, w8, w9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w7 <= 1'b0;
      w8 <= 1'b0;
      w9 <= 1'b0;
    end else if (clr) begin
      w7 <= 1'b0;
      w8 <= 1'b0;
      w9 <= 1'b0;
    end else if (en) begin
      w7 <= w7 ^ x;
      w8 <= ~w8 & x;
      w9 <= ~w9 | x;
    end
  end

  assign z = ~(w7 | w8 | w9);

endmodule

// File: rtl/des_seq_ctrl.sv
// Round-robin scheduler that time-shares one des_core between N_REQ
// requesters and returns the per-bit detector output as a W-bit word.
module des_seq_ctrl
  import des_seq_ctrl_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [W-1:0]       resp_data,
  input  logic               resp_ready,
  output logic               busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   data_q;
  logic [W-1:0]   res;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           core_z;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Grant is combinational so the requester sees ready in the accept cycle.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    if (state == IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_any && req_valid[rr_idx(rr_ptr, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = rr_idx(rr_ptr, k);
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  des_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE && gnt_any),
    .en    (state == SHIFT),
    .x     (data_q[cnt]),
    .z     (core_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      cnt        <= '0;
      res        <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          cur_id <= gnt_idx;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= SHIFT;
        end
        // z lags x by one edge, so bit k of the result lands at cnt=k+1 (or TAIL).
        SHIFT: begin
          if (cnt != '0) res[cnt - 1'b1] <= core_z;
          if (cnt == LAST) state <= TAIL;
          else             cnt   <= cnt + 1'b1;
        end
        TAIL: begin
          res[W-1]   <= core_z;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          rr_ptr     <= wrap_inc(cur_id);
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Job word is datapath only; it is reloaded on every accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_any) data_q <= req_data[gnt_idx*W +: W];
  end

  assign resp_id   = cur_id;
  assign resp_data = res;

endmodule

// File: tb/tb_des_seq_ctrl.sv
// Directed bench for des_seq_ctrl: vector table of single jobs plus
// hand-written reset, arbitration, backpressure and fairness sequences.
module tb_des_seq_ctrl;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [W-1:0]       resp_data;
  logic               resp_ready;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;
  int multi_hot = 0;

  des_seq_ctrl #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if ($countones(req_ready) > 1) multi_hot++;
  end

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for the grant of exp_id, runs the job and completes the handshake.
  task automatic serve(input int exp_id, input logic [7:0] exp_data, input bit drop);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 32'(req_ready), 32'(4'b0001 << exp_id));
    @(posedge clk); #1;
    if (drop) req_valid[exp_id] = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, W + 1);
    chk("resp_id", 32'(resp_id), exp_id);
    chk("resp_data", 32'(resp_data), 32'(exp_data));
    chk("busy_job", 32'(busy), 1);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    logic [7:0] arb_exp [4];

    vecs[0] = '{0, 8'h00, 8'hAA};
    vecs[1] = '{2, 8'hFF, 8'h00};
    vecs[2] = '{1, 8'h01, 8'h00};
    vecs[3] = '{3, 8'h03, 8'h54};
    vecs[4] = '{0, 8'h80, 8'h2A};
    vecs[5] = '{1, 8'h55, 8'h88};
    vecs[6] = '{2, 8'hAA, 8'h10};

    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    #1;
    chk("rst_outputs", {resp_valid, busy, 2'(resp_id), resp_data, req_ready}, 0);
    do_reset();

    foreach (vecs[i]) begin
      req_data[vecs[i].id*W +: W] = vecs[i].data;
      req_valid[vecs[i].id] = 1'b1;
      serve(vecs[i].id, vecs[i].exp, 1'b1);
      @(negedge clk);
    end

    // Reset mid-SHIFT while rr_ptr points at 3.
    req_data[1*W +: W] = 8'h00;
    req_valid[1] = 1'b1;
    #1 chk("rst_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid", {resp_valid, busy, 2'(resp_id), resp_data, req_ready}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (resp_valid || busy) seen++;
    end
    chk("rst_no_resp", seen, 0);
    @(negedge clk);
    req_data[0*W +: W] = 8'hFF;
    req_data[3*W +: W] = 8'h00;
    req_valid = 4'b1001;
    #1 chk("rst_rrptr", 32'(req_ready), 32'b0001);
    serve(0, 8'h00, 1'b1);
    req_valid = '0;

    // All four requesters valid from reset: grants must go 0,1,2,3.
    do_reset();
    req_data = {8'h03, 8'h01, 8'hFF, 8'h00};
    arb_exp[0] = 8'hAA; arb_exp[1] = 8'h00; arb_exp[2] = 8'h00; arb_exp[3] = 8'h54;
    req_valid = 4'b1111;
    for (int g = 0; g < N_REQ; g++) serve(g, arb_exp[g], 1'b1);
    chk("arb_onehot", multi_hot, 0);

    // Fairness: requesters 1 and 3 both stay valid.
    @(negedge clk);
    req_data[1*W +: W] = 8'hFF;
    req_data[3*W +: W] = 8'h00;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) serve(1, 8'h00, 1'b0);
      else            serve(3, 8'hAA, 1'b0);
    end
    req_valid = '0;

    // Backpressure: hold resp_ready low for 20 cycles with another request pending.
    @(negedge clk);
    req_data[2*W +: W] = 8'h55;
    req_data[0*W +: W] = 8'h00;
    req_valid = 4'b0100;
    #1 chk("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1; req_valid = 4'b0001;
    seen = 0;
    while (!resp_valid && seen < 40) begin
      @(posedge clk); #1; seen++;
    end
    chk("bp_latency", seen, W + 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {resp_valid, 2'(resp_id), resp_data, req_ready}, {1'b1, 2'd2, 8'h88, 4'b0000});
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp_release", {resp_valid, busy, req_ready}, {1'b0, 1'b0, 4'b0001});
    serve(0, 8'hAA, 1'b1);
    chk("final_onehot", multi_hot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
